// File: rtl/reaction_timer_ctrl_pkg.sv
// Shared types for the reaction-timer controller: FSM states and display status codes.
package reaction_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT_DELAY,
    REACT,
    DONE,
    TIMEOUT,
    EARLY
  } state_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_TIME  = 2'd2,
    ST_FAULT = 2'd3
  } status_t;

endpackage

// File: rtl/reaction_timer_ctrl_ms_tick_gen.sv
// Millisecond prescaler: counts 0..MS_TICKS-1 while enabled, tick on the terminal count.
module ms_tick_gen #(
  parameter int unsigned MS_TICKS = 100_000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);

  localparam int unsigned CW = (MS_TICKS > 1) ? $clog2(MS_TICKS) : 1;
  localparam logic [CW-1:0] LP_LAST = CW'(MS_TICKS - 1);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == LP_LAST);
  assign o_tick = i_en && w_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_last ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/reaction_timer_ctrl.sv
// Reaction-timer sequencer: arms the random delay, lights the LED, times the response in ms.
module reaction_timer_ctrl
  import reaction_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned MAX_MS      = 1000,
  parameter int unsigned MS_WIDTH    = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_start_btn,
  input  logic                i_stop_btn,
  input  logic                i_clear_btn,
  input  logic                i_delay_complete,
  output logic                o_delay_start,
  output logic                o_stim_led,
  output logic [MS_WIDTH-1:0] o_reaction_ms,
  output logic [1:0]          o_status
);

  localparam int unsigned MS_TICKS = CLK_FREQ_HZ / 1000;
  localparam logic [MS_WIDTH-1:0] LP_MAX      = MS_WIDTH'(MAX_MS);
  localparam logic [MS_WIDTH-1:0] LP_MAX_LAST = MS_WIDTH'(MAX_MS - 1);

  state_t              r_state, w_next_state;
  status_t             r_status, w_next_status;
  logic                r_delay_start, w_next_delay_start;
  logic                r_stim_led, w_next_stim_led;
  logic [MS_WIDTH-1:0] r_ms, w_next_ms;
  logic                w_ms_tick;
  logic                w_in_react;

  assign w_in_react = (r_state == REACT);

  // Prescaler is held at zero outside REACT so each trial starts on a fresh ms boundary.
  ms_tick_gen #(
    .MS_TICKS (MS_TICKS)
  ) u_ms_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (!w_in_react),
    .i_en   (w_in_react),
    .o_tick (w_ms_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_status      <= ST_IDLE;
      r_delay_start <= 1'b0;
      r_stim_led    <= 1'b0;
      r_ms          <= '0;
    end else begin
      r_state       <= w_next_state;
      r_status      <= w_next_status;
      r_delay_start <= w_next_delay_start;
      r_stim_led    <= w_next_stim_led;
      r_ms          <= w_next_ms;
    end
  end

  always_comb begin
    w_next_state       = r_state;
    w_next_status      = r_status;
    w_next_delay_start = 1'b0;
    w_next_stim_led    = 1'b0;
    w_next_ms          = r_ms;

    if ((r_state != IDLE) && i_clear_btn) begin
      w_next_state  = IDLE;
      w_next_status = ST_IDLE;
      w_next_ms     = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_next_status = ST_IDLE;
          w_next_ms     = '0;
          if (i_start_btn) begin
            w_next_state       = ARM;
            w_next_status      = ST_WAIT;
            w_next_delay_start = 1'b1;
          end
        end
        ARM: begin
          w_next_state  = WAIT_DELAY;
          w_next_status = ST_WAIT;
        end
        WAIT_DELAY: begin
          w_next_status = ST_WAIT;
          if (i_stop_btn) begin
            w_next_state  = EARLY;
            w_next_status = ST_FAULT;
          end else if (i_delay_complete) begin
            w_next_state    = REACT;
            w_next_status   = ST_TIME;
            w_next_stim_led = 1'b1;
            w_next_ms       = '0;
          end
        end
        REACT: begin
          w_next_status   = ST_TIME;
          w_next_stim_led = 1'b1;
          if (i_stop_btn) begin
            w_next_state    = DONE;
            w_next_stim_led = 1'b0;
          end else if (w_ms_tick) begin
            if (r_ms == LP_MAX_LAST) begin
              w_next_state    = TIMEOUT;
              w_next_stim_led = 1'b0;
              w_next_ms       = LP_MAX;
            end else begin
              w_next_ms = r_ms + MS_WIDTH'(1);
            end
          end
        end
        DONE, TIMEOUT: begin
          w_next_status = ST_TIME;
        end
        EARLY: begin
          w_next_status = ST_FAULT;
        end
        default: begin
          w_next_state  = IDLE;
          w_next_status = ST_IDLE;
          w_next_ms     = '0;
        end
      endcase
    end
  end

  assign o_delay_start = r_delay_start;
  assign o_stim_led    = r_stim_led;
  assign o_reaction_ms = r_ms;
  assign o_status      = r_status;

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Randomized and directed bench for reaction_timer_ctrl against an elapsed-time reference model.
module tb_reaction_timer_ctrl;

  localparam int unsigned CLK_HZ = 10_000;
  localparam int unsigned TPM    = CLK_HZ / 1000;
  localparam int unsigned MAXMS  = 1000;
  localparam int unsigned MSW    = 10;

  localparam int PH_IDLE  = 0;
  localparam int PH_ARM   = 1;
  localparam int PH_WAIT  = 2;
  localparam int PH_REACT = 3;
  localparam int PH_HELD  = 4;
  localparam int PH_EARLY = 5;

  logic           clk = 1'b0;
  logic           reset;
  logic           i_start_btn, i_stop_btn, i_clear_btn, i_delay_complete;
  logic           o_delay_start, o_stim_led;
  logic [MSW-1:0] o_reaction_ms;
  logic [1:0]     o_status;

  int n_checks = 0;
  int n_errors = 0;

  int m_phase;
  int m_el;
  int m_ms;

  always #5 clk = ~clk;

  reaction_timer_ctrl #(
    .CLK_FREQ_HZ (CLK_HZ),
    .MAX_MS      (MAXMS),
    .MS_WIDTH    (MSW)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .i_start_btn      (i_start_btn),
    .i_stop_btn       (i_stop_btn),
    .i_clear_btn      (i_clear_btn),
    .i_delay_complete (i_delay_complete),
    .o_delay_start    (o_delay_start),
    .o_stim_led       (o_stim_led),
    .o_reaction_ms    (o_reaction_ms),
    .o_status         (o_status)
  );

  task automatic chk(input string tag, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = PH_IDLE;
    m_el    = 0;
    m_ms    = 0;
  endtask

  // Reaction time is the whole number of elapsed ms since the LED lit, capped at MAXMS.
  task automatic model_edge(input bit s, input bit p, input bit c, input bit d);
    if (m_phase == PH_IDLE) begin
      m_ms = 0;
      if (s) m_phase = PH_ARM;
    end else if (c) begin
      m_phase = PH_IDLE;
      m_ms    = 0;
    end else begin
      case (m_phase)
        PH_ARM:  m_phase = PH_WAIT;
        PH_WAIT: begin
          if (p) m_phase = PH_EARLY;
          else if (d) begin
            m_phase = PH_REACT;
            m_el    = 0;
          end
        end
        PH_REACT: begin
          if (p) begin
            m_ms    = m_el / TPM;
            m_phase = PH_HELD;
          end else begin
            m_el++;
            if (m_el / TPM >= MAXMS) begin
              m_ms    = MAXMS;
              m_phase = PH_HELD;
            end
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_outputs(input string tag);
    int unsigned e_status;
    int unsigned e_ms;
    case (m_phase)
      PH_IDLE:           e_status = 0;
      PH_ARM, PH_WAIT:   e_status = 1;
      PH_REACT, PH_HELD: e_status = 2;
      default:           e_status = 3;
    endcase
    e_ms = (m_phase == PH_REACT) ? m_el / TPM : m_ms;
    chk({tag, "_ds"},     int'(o_delay_start), int'(m_phase == PH_ARM));
    chk({tag, "_led"},    int'(o_stim_led),    int'(m_phase == PH_REACT));
    chk({tag, "_status"}, int'(o_status),      e_status);
    chk({tag, "_ms"},     int'(o_reaction_ms), e_ms);
  endtask

  task automatic cyc(input bit s, input bit p, input bit c, input bit d, input string tag);
    i_start_btn      = s;
    i_stop_btn       = p;
    i_clear_btn      = c;
    i_delay_complete = d;
    @(posedge clk);
    if (reset) model_reset();
    else model_edge(s, p, c, d);
    #1;
    i_start_btn      = 1'b0;
    i_stop_btn       = 1'b0;
    i_clear_btn      = 1'b0;
    i_delay_complete = 1'b0;
    check_outputs(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, tag);
  endtask

  task automatic noise(input int n, input string tag);
    for (int i = 0; i < n; i++)
      cyc(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 1'b0,
          bit'($urandom_range(0, 1)), tag);
  endtask

  initial begin
    reset            = 1'b1;
    i_start_btn      = 1'b0;
    i_stop_btn       = 1'b0;
    i_clear_btn      = 1'b0;
    i_delay_complete = 1'b0;
    model_reset();
    #1;
    check_outputs("reset");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, "reset_hold");
    reset = 1'b0;

    // Test 1: basic trial, 235 ms reaction.
    idle(4, "t1_idle");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, "t1_start");
    chk("t1_ds_pulse", int'(o_delay_start), 1);
    idle(1, "t1_arm");
    chk("t1_ds_low", int'(o_delay_start), 0);
    idle(30, "t1_wait");
    cyc(1'b0, 1'b0, 1'b0, 1'b1, "t1_dc");
    chk("t1_led_on", int'(o_stim_led), 1);
    idle(2354, "t1_react");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, "t1_stop");
    chk("t1_ms235", int'(o_reaction_ms), 235);
    noise(5, "t1_held");
    cyc(1'b0, 1'b0, 1'b1, 1'b0, "t1_clear");

    // Test 2: early stop, then a late delay_complete is ignored.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, "t2_start");
    idle(10, "t2_wait");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, "t2_stop");
    idle(5, "t2_early");
    cyc(1'b0, 1'b0, 1'b0, 1'b1, "t2_dc");
    chk("t2_fault", int'(o_status), 3);
    noise(4, "t2_noise");
    cyc(1'b0, 1'b0, 1'b1, 1'b0, "t2_clear");

    // Test 3: stop and delay_complete together.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, "t3_start_stop");
    idle(5, "t3_wait");
    cyc(1'b0, 1'b1, 1'b0, 1'b1, "t3_both");
    chk("t3_fault", int'(o_status), 3);
    idle(3, "t3_early");
    cyc(1'b0, 1'b0, 1'b1, 1'b0, "t3_clear");

    // Test 4: no response, timeout at MAXMS.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, "t4_start");
    idle(8, "t4_wait");
    cyc(1'b0, 1'b0, 1'b0, 1'b1, "t4_dc");
    idle(10000, "t4_react");
    chk("t4_timeout_ms", int'(o_reaction_ms), MAXMS);
    noise(6, "t4_held");
    cyc(1'b0, 1'b0, 1'b1, 1'b0, "t4_clear");

    // Test 5: stop coinciding with the 999->1000 tick.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, "t5_start");
    idle(3, "t5_wait");
    cyc(1'b0, 1'b0, 1'b0, 1'b1, "t5_dc");
    idle(9999, "t5_react");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, "t5_stop");
    chk("t5_ms999", int'(o_reaction_ms), 999);
    idle(3, "t5_held");
    cyc(1'b0, 1'b0, 1'b1, 1'b0, "t5_clear");

    // Test 6: async reset mid-REACT, then clear during ARM.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, "t6_start");
    idle(3, "t6_wait");
    cyc(1'b0, 1'b0, 1'b0, 1'b1, "t6_dc");
    idle(437, "t6_react");
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_outputs("t6_async_rst");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, "t6_rst_hold");
    reset = 1'b0;
    idle(2, "t6_post_rst");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, "t6_start2");
    cyc(1'b0, 1'b0, 1'b1, 1'b0, "t6_clear_arm");
    chk("t6_ds_killed", int'(o_delay_start), 0);
    idle(2, "t6_post_clear");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, "t6_start3");
    idle(4, "t6_wait3");
    cyc(1'b0, 1'b0, 1'b0, 1'b1, "t6_dc3");
    idle(123, "t6_react3");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, "t6_stop3");
    cyc(1'b0, 1'b0, 1'b1, 1'b0, "t6_clear3");

    // Randomized trials.
    for (int t = 0; t < 12; t++) begin
      idle($urandom_range(0, 5), "rnd_idle");
      cyc(1'b1, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 1'b0, "rnd_start");
      if ($urandom_range(0, 9) == 0) cyc(1'b0, 1'b0, 1'b1, 1'b0, "rnd_arm_clear");
      for (int i = 0; i < int'($urandom_range(1, 40)); i++)
        cyc(1'b0, $urandom_range(0, 29) == 0, 1'b0, 1'b0, "rnd_wait");
      cyc(1'b0, $urandom_range(0, 4) == 0, 1'b0, 1'b1, "rnd_dc");
      for (int i = 0; i < int'($urandom_range(0, 1500)); i++)
        cyc($urandom_range(0, 19) == 0, 1'b0, 1'b0, $urandom_range(0, 19) == 0, "rnd_react");
      cyc(1'b0, 1'b1, 1'b0, 1'b0, "rnd_stop");
      noise($urandom_range(1, 6), "rnd_held");
      cyc(1'b0, 1'b0, 1'b1, 1'b0, "rnd_clear");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
